// File: rtl/pwm_gen.sv
// Configurable PWM generator. A double-buffered period/duty config is applied only
// at period boundaries, and disabling always lets the current period run to its end.
module pwm_gen #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  output logic                 pwm_out,
  output logic                 period_end,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] act_p_q, act_p_d, act_d_q, act_d_d;
  logic [CNT_WIDTH-1:0] pend_p_q, pend_p_d, pend_d_q, pend_d_d;
  logic                 pend_flag_q, pend_flag_d;
  logic                 pwm_d, pe_d;
  logic [CNT_WIDTH-1:0] cnt_inc, nxt_p, nxt_d;
  logic                 wrap;

  assign cfg_ready = !pend_flag_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_p_d     = act_p_q;
    act_d_d     = act_d_q;
    pend_p_d    = pend_p_q;
    pend_d_d    = pend_d_q;
    pend_flag_d = pend_flag_q;
    pwm_d       = 1'b0;
    pe_d        = 1'b0;
    cnt_inc     = cnt_q + ONE;
    wrap        = (cnt_q == act_p_q - ONE);
    // Config that will be active after a boundary edge (pending wins if present)
    nxt_p       = pend_flag_q ? pend_p_q : act_p_q;
    nxt_d       = pend_flag_q ? pend_d_q : act_d_q;

    if (cfg_valid && !pend_flag_q) begin
      pend_p_d    = cfg_period;
      pend_d_d    = cfg_duty;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_flag_q) begin
          act_p_d     = pend_p_q;
          act_d_d     = pend_d_q;
          pend_flag_d = 1'b0;
        end
        if (enable && (nxt_p != '0)) begin
          state_d = RUN;
          pwm_d   = (nxt_d != '0);
          pe_d    = (nxt_p == ONE);
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_flag_q) begin
            act_p_d     = pend_p_q;
            act_d_d     = pend_d_q;
            pend_flag_d = 1'b0;
          end
          // Stop only at a boundary; a zero period also forces a stop
          if (enable && (nxt_p != '0)) begin
            state_d = RUN;
            pwm_d   = (nxt_d != '0);
            pe_d    = (nxt_p == ONE);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_inc;
          pwm_d   = (cnt_inc < act_d_q);
          pe_d    = (cnt_inc == act_p_q - ONE);
          state_d = enable ? RUN : STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_p_q     <= '0;
      act_d_q     <= '0;
      pend_p_q    <= '0;
      pend_d_q    <= '0;
      pend_flag_q <= 1'b0;
      pwm_out     <= 1'b0;
      period_end  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_p_q     <= act_p_d;
      act_d_q     <= act_d_d;
      pend_p_q    <= pend_p_d;
      pend_d_q    <= pend_d_d;
      pend_flag_q <= pend_flag_d;
      pwm_out     <= pwm_d;
      period_end  <= pe_d;
    end
  end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the period/duty counters in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit, level request to run PWM output.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit, new configuration offered.
REQ-006 The block SHALL have port cfg_ready, output, 1 bit, configuration can be accepted.
REQ-007 The block SHALL have port cfg_period, input, CNT_WIDTH bits, period P in clk cycles.
REQ-008 The block SHALL have port cfg_duty, input, CNT_WIDTH bits, high time D in clk cycles.
REQ-009 The block SHALL have port pwm_out, output, 1 bit, registered PWM waveform.
REQ-010 The block SHALL have port period_end, output, 1 bit, registered one-cycle pulse on the last cycle of each period.
REQ-011 The block SHALL have port busy, output, 1 bit, high in states RUN and STOPPING.

Function
REQ-012 The block SHALL hold an active config (act_p, act_d) and a pending config (pend_p, pend_d, pend_flag).
REQ-013 A config SHALL be accepted on a clock edge where cfg_valid and cfg_ready are both high; it loads the pending regs and sets pend_flag.
REQ-014 cfg_ready SHALL equal !pend_flag, so at most one config is pending; cfg_valid while cfg_ready is low SHALL be ignored and the offered data dropped.
REQ-015 The FSM SHALL have states IDLE, RUN and STOPPING.
REQ-016 In IDLE, a set pend_flag SHALL be applied on the next edge: active <= pending and pend_flag cleared.
REQ-017 In IDLE, pwm_out SHALL be 0, period_end SHALL be 0 and cnt SHALL be 0.
REQ-018 IDLE -> RUN SHALL occur on an edge where enable=1 and act_p != 0; at that edge cnt <= 0 and pwm_out <= (0 < act_d).
REQ-019 In RUN, each edge SHALL set cnt <= cnt+1, or 0 when cnt == act_p-1 (wrap); pwm_out <= (cnt_next < act_d).
REQ-020 As a result, pwm_out SHALL be high exactly on cycles k < D of each period k = 0..P-1.
REQ-021 D >= P SHALL give a constant high output and D = 0 a constant low output.
REQ-022 At the wrap edge with pend_flag set, active <= pending and pend_flag cleared; the new P and D take effect from cycle k=0 of the following period, and the comparison uses the new D.
REQ-023 Active config SHALL never change mid-period.
REQ-024 period_end SHALL be registered high during the cycle in which cnt == act_p-1, for exactly one cycle per period; for P=1 it SHALL be high every cycle.
REQ-025 In RUN, enable=0 SHALL move the FSM to STOPPING; STOPPING SHALL complete the current period unchanged.
REQ-026 At the wrap edge in STOPPING, the FSM SHALL go to IDLE with pwm_out <= 0, applying any pending config.
REQ-027 enable re-asserted during STOPPING SHALL return the FSM to RUN with no glitch or restart of cnt.
REQ-028 If act_p == 0 is applied at a wrap, the FSM SHALL go to IDLE, forcing pwm_out 0.
REQ-029 If act_p == 0 while in IDLE, enable SHALL be ignored.
REQ-030 All arithmetic SHALL be unsigned CNT_WIDTH-bit; P up to 2^CNT_WIDTH-1 SHALL be supported without overflow of cnt.
REQ-031 An acceptance and an application on the same wrap edge SHALL not occur, because cfg_ready=0 while pend_flag=1.

Reset
REQ-032 Asserting n_rst=0 SHALL immediately, asynchronously and independent of clk, force state IDLE, cnt=0, act_p=0, act_d=0, pend_p=0, pend_d=0, pend_flag=0, pwm_out=0, period_end=0, busy=0 and cfg_ready=1.
REQ-033 Reset asserted mid-period SHALL abort the output low at once, and any pending config SHALL be lost.
REQ-034 After n_rst deasserts, the first accepted edge SHALL follow normal rules.

Verification
REQ-035 Bench scenario: config P=10, D=3 in IDLE, then enable=1 -> pwm_out high 3 cycles, low 7, repeating; period_end high on cycles 9, 19, 29 after start.
REQ-036 Bench scenario: RUN with P=10, D=3; offer P=4, D=1 at cycle k=5 -> cfg_ready falls, the current period completes as 10/3, the next period is 4/1, then cfg_ready=1.
REQ-037 Bench scenario: D=0 -> pwm_out always 0; D=10 with P=10 -> always 1; D=12 with P=10 -> always 1; period_end still pulses every 10 cycles in each case.
REQ-038 Bench scenario: enable=0 at k=2 of a P=8 period -> busy stays high until the wrap, pwm_out follows the waveform to k=7, then IDLE with pwm_out=0.
REQ-039 Bench scenario: enable re-asserted at k=5 of the same period -> continuous waveform with no restart.
REQ-040 Bench scenario: n_rst pulse asynchronously mid-high-phase -> pwm_out=0 before the next clk edge, cfg_ready=1, and enable=1 afterward is ignored until a nonzero-P config is applied.
REQ-041 Bench scenario: cfg_valid held with changing data while cfg_ready=0 -> only the first accepted value is applied.
REQ-042 Bench scenario: P=1, D=1 -> pwm_out constant 1 and period_end constant 1 in RUN.
